// File: rtl/decode_issue_ctrl_if.sv
// Handshake bundle between fetch, the decode sequencer, the sign-extender and execute.
// The slave modport is the decode stage; the master modport is its environment.
interface decode_issue_ctrl_if #(
  parameter int PC_W = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic [1:0]      imm_src;
  logic [63:0]     imm_in;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [63:0]     out_imm;
  logic [4:0]      out_rd;
  logic [2:0]      out_kind;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, imm_in, out_ready,
    output in_ready, imm_src, out_valid, out_pc, out_imm, out_rd, out_kind, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, imm_in, out_ready,
    input  in_ready, imm_src, out_valid, out_pc, out_imm, out_rd, out_kind, out_illegal
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencer: one-entry stage register feeding an in-order FIFO of
// classified instructions with their 64-bit immediates.
module decode_issue_ctrl #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 64
) (
  input logic                clk,
  input logic                reset,
  input logic                flush,
  decode_issue_ctrl_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    KIND_R   = 3'd0,
    KIND_I   = 3'd1,
    KIND_S   = 3'd2,
    KIND_B   = 3'd3,
    KIND_J   = 3'd4,
    KIND_U   = 3'd5,
    KIND_ILL = 3'd7
  } kind_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [63:0]     imm;
    logic [4:0]      rd;
    logic [2:0]      kind;
    logic            illegal;
  } entry_t;

  logic            sValid_q, sValid_d;
  logic [31:0]     sInstr_q, sInstr_d;
  logic [PC_W-1:0] sPc_q, sPc_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  entry_t          mem_q [DEPTH];

  logic [6:0] opcode;
  kind_e      kind;
  logic       illegal;
  logic [63:0] imm;
  logic       accept;
  logic       drain;
  logic       consume;
  entry_t     wrEntry;
  entry_t     head;
  logic       unusedImmHi;

  // The extender only produces a 32-bit result; its upper half is discarded.
  assign unusedImmHi = ^bus.imm_in[63:32];

  assign opcode = sInstr_q[6:0];

  always_comb begin
    bus.imm_src = 2'b00;
    case (opcode)
      7'b0100011: bus.imm_src = 2'b01;
      7'b1100011: bus.imm_src = 2'b10;
      7'b1101111: bus.imm_src = 2'b11;
      default:    bus.imm_src = 2'b00;
    endcase
  end

  always_comb begin
    kind    = KIND_ILL;
    illegal = 1'b1;
    case (opcode)
      7'b0110011, 7'b0111011: begin
        kind = KIND_R; illegal = 1'b0;
      end
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        kind = KIND_I; illegal = 1'b0;
      end
      7'b0100011: begin
        kind = KIND_S; illegal = 1'b0;
      end
      7'b1100011: begin
        kind = KIND_B; illegal = 1'b0;
      end
      7'b1101111: begin
        kind = KIND_J; illegal = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        kind = KIND_U; illegal = 1'b0;
      end
      default: begin
        kind = KIND_ILL; illegal = 1'b1;
      end
    endcase
  end

  // U-type immediates never go through the extender; they are built from the word itself.
  always_comb begin
    imm = 64'd0;
    case (kind)
      KIND_I, KIND_S, KIND_B, KIND_J: imm = {{32{bus.imm_in[31]}}, bus.imm_in[31:0]};
      KIND_U:                         imm = {{32{sInstr_q[31]}}, sInstr_q[31:12], 12'b0};
      default:                        imm = 64'd0;
    endcase
  end

  assign bus.in_ready = !sValid_q || (count_q < CNT_FULL);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = sValid_q && (count_q < CNT_FULL);
  assign consume      = bus.out_valid && bus.out_ready;

  always_comb begin
    wrEntry         = '0;
    wrEntry.pc      = sPc_q;
    wrEntry.imm     = imm;
    wrEntry.rd      = sInstr_q[11:7];
    wrEntry.kind    = kind;
    wrEntry.illegal = illegal;
  end

  always_comb begin
    sValid_d = sValid_q;
    sInstr_d = sInstr_q;
    sPc_d    = sPc_q;
    count_d  = count_q;
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    if (drain) begin
      sValid_d = 1'b0;
      wrPtr_d  = wrPtr_q + AW'(1);
    end
    if (accept) begin
      sValid_d = 1'b1;
      sInstr_d = bus.in_instr;
      sPc_d    = bus.in_pc;
    end
    if (consume) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({drain, consume})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // A redirect squashes everything in flight but keeps the ring position.
    if (flush) begin
      sValid_d = 1'b0;
      count_d  = '0;
      wrPtr_d  = wrPtr_q;
      rdPtr_d  = rdPtr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sValid_q <= 1'b0;
      sInstr_q <= '0;
      sPc_q    <= '0;
      count_q  <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
    end else begin
      sValid_q <= sValid_d;
      sInstr_q <= sInstr_d;
      sPc_q    <= sPc_d;
      count_q  <= count_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !flush && drain) begin
      mem_q[wrPtr_q] <= wrEntry;
    end
  end

  // Head fields are forced to zero whenever the FIFO is empty.
  assign head            = mem_q[rdPtr_q];
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_pc      = bus.out_valid ? head.pc      : '0;
  assign bus.out_imm     = bus.out_valid ? head.imm     : '0;
  assign bus.out_rd      = bus.out_valid ? head.rd      : '0;
  assign bus.out_kind    = bus.out_valid ? head.kind    : '0;
  assign bus.out_illegal = bus.out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: decode vectors, back-pressure ordering,
// flush of a full pipeline and mid-stream reset, with a behavioural sign-extender.
module tb_decode_issue_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic [31:0] extInstr;
  logic [31:0] ext32;
  int assertCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  decode_issue_ctrl_if #(.PC_W(64)) bus ();

  decode_issue_ctrl #(.DEPTH(2), .PC_W(64)) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus.slave)
  );

  // Sign-extender model; upper half is junk the DUT must ignore.
  always_comb begin
    ext32 = 32'd0;
    case (bus.imm_src)
      2'b00: ext32 = {{20{extInstr[31]}}, extInstr[31:20]};
      2'b01: ext32 = {{20{extInstr[31]}}, extInstr[31:25], extInstr[11:7]};
      2'b10: ext32 = {{19{extInstr[31]}}, extInstr[31], extInstr[7], extInstr[30:25], extInstr[11:8], 1'b0};
      default: ext32 = {{11{extInstr[31]}}, extInstr[31], extInstr[19:12], extInstr[20], extInstr[30:21], 1'b0};
    endcase
    bus.imm_in = {32'hDEADBEEF, ext32};
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] pc);
    checkOutput("in_ready before send", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    extInstr     = instr;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic runSingle(input string name, input logic [31:0] instr, input logic [63:0] pc,
                           input logic [1:0] expSrc, input logic [63:0] expImm,
                           input logic [2:0] expKind, input logic [4:0] expRd, input logic expIll);
    bus.out_ready = 1'b1;
    applyStimulus(instr, pc);
    checkOutput({name, " imm_src"}, 64'(bus.imm_src), 64'(expSrc));
    checkOutput({name, " no bypass"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput({name, " out_valid"}, 64'(bus.out_valid), 64'd1);
    checkOutput({name, " out_pc"}, bus.out_pc, pc);
    checkOutput({name, " out_imm"}, bus.out_imm, expImm);
    checkOutput({name, " out_kind"}, 64'(bus.out_kind), 64'(expKind));
    checkOutput({name, " out_rd"}, 64'(bus.out_rd), 64'(expRd));
    checkOutput({name, " out_illegal"}, 64'(bus.out_illegal), 64'(expIll));
    @(posedge clk);
    #1;
    checkOutput({name, " drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
    checkOutput({name, " out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({name, " imm_src"}, 64'(bus.imm_src), 64'd0);
    checkOutput({name, " out_pc"}, bus.out_pc, 64'd0);
    checkOutput({name, " out_imm"}, bus.out_imm, 64'd0);
    checkOutput({name, " out_kind"}, 64'(bus.out_kind), 64'd0);
    checkOutput({name, " out_rd"}, 64'(bus.out_rd), 64'd0);
    checkOutput({name, " out_illegal"}, 64'(bus.out_illegal), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] expQ[$];
    logic [63:0] expPc;
    int k;
    int emitted;

    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'd0;
    bus.in_pc     = 64'd0;
    bus.out_ready = 1'b0;
    extInstr      = 32'd0;
    reset         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    reset = 1'b1;

    runSingle("addi", 32'hFFF00093, 64'h100, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 5'd1, 1'b0);
    runSingle("sw",   32'h00112623, 64'h104, 2'b01, 64'd12,                  3'd2, 5'd12, 1'b0);
    runSingle("beq",  32'hFE000CE3, 64'h108, 2'b10, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 5'd25, 1'b0);
    runSingle("jal",  32'hFFDFF06F, 64'h10C, 2'b11, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 5'd0, 1'b0);
    runSingle("lui",  32'h123452B7, 64'h110, 2'b00, 64'h0000_0000_1234_5000, 3'd5, 5'd5, 1'b0);
    runSingle("add",  32'h002081B3, 64'h114, 2'b00, 64'd0,                   3'd0, 5'd3, 1'b0);
    runSingle("zero", 32'h00000000, 64'h118, 2'b00, 64'd0,                   3'd7, 5'd0, 1'b1);

    // Back-pressure: four addi offered with execute stalled.
    bus.out_ready = 1'b0;
    bus.in_instr  = 32'hFFF00093;
    extInstr      = 32'hFFF00093;
    k = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      bus.in_valid = (k < 4);
      bus.in_pc    = 64'h1000 + 64'(4 * k);
      if (bus.out_valid) checkOutput("stall head pc", bus.out_pc, 64'h1000);
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back(bus.in_pc);
        k++;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("bp accepted", 64'(k), 64'd3);
    checkOutput("bp in_ready", 64'(bus.in_ready), 64'd0);

    bus.out_ready = 1'b1;
    emitted = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      bus.in_valid = (k < 4);
      bus.in_pc    = 64'h1000 + 64'(4 * k);
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back(bus.in_pc);
        k++;
      end
      if (bus.out_valid) begin
        expPc = (expQ.size() > 0) ? expQ.pop_front() : 64'hBAD;
        checkOutput("bp order pc", bus.out_pc, expPc);
        checkOutput("bp imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        emitted++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checkOutput("bp fourth accepted", 64'(k), 64'd4);
    checkOutput("bp emitted", 64'(emitted), 64'd4);
    checkOutput("bp empty", 64'(bus.out_valid), 64'd0);

    // Flush with FIFO full, stage valid and a new instruction offered.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = 64'h2000 + 64'(4 * i);
      @(posedge clk);
      #1;
    end
    checkOutput("flush precond full", 64'(bus.in_ready), 64'd0);
    bus.in_pc = 64'h2100;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("flush in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("flush nothing emitted", 64'(bus.out_valid), 64'd0);
    end
    runSingle("post-flush lui", 32'h123452B7, 64'h3000, 2'b00, 64'h0000_0000_1234_5000, 3'd5, 5'd5, 1'b0);

    // Reset while one entry sits in the FIFO and another in the stage.
    bus.out_ready = 1'b0;
    applyStimulus(32'h00112623, 64'h4000);
    applyStimulus(32'hFFF00093, 64'h4004);
    checkOutput("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    checkResetState("mid reset");
    runSingle("post-reset jal", 32'hFFDFF06F, 64'h5000, 2'b11, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 5'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
